fix_msg_link: RTL and testbench

Store-and-forward byte link that carries complete FIX messages from one engine's outbound port (`fifo_write_*_o` / `message_*_o` / `end_*_o`) to the peer engine's inbound port (`message_*_i` / `new_message_*_i`) inside `end_to_end_system`. It replaces the bench's behavioural buffer between initiator and acceptor: one instance runs initiator→acceptor and a second runs acceptor→initiator. Only complete, non-overflowed messages are forwarded, each preceded by a one-cycle new-message pulse.

---
 rtl/fix_link_pkg.sv | 23 ++
 rtl/fix_link_ram.sv | 26 ++
 rtl/fix_msg_link.sv | 191 +++++++++++++++++++
 tb/tb_fix_msg_link.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_link_pkg.sv
// Shared types and sizing for the FIX message link: FSM state enums,
// length-queue geometry and the default byte-storage depth.
package fix_link_pkg;

  localparam int DEFAULT_DEPTH = 512;
  localparam int LEN_Q_DEPTH   = 16;
  localparam int LEN_W         = 16;
  localparam int LQ_AW         = $clog2(LEN_Q_DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ANNOUNCE,
    R_STREAM,
    R_GAP
  } r_state_t;

endpackage

// File: rtl/fix_link_ram.sv
// Simple dual-port DEPTH x 8 byte store: synchronous write, asynchronous read.
module fix_link_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; the pointers decide what is valid,
  // and a reset port would stop the array mapping onto RAM cells.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fix_msg_link.sv
// Store-and-forward FIX message link: buffers whole frames, forwards only
// committed ones. Optional macro FIX_LINK_DROP_PREFIX_EN strips each frame's first byte.
module fix_msg_link
  import fix_link_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] data_i,
  input  logic       end_i,
  output logic       fifo_full_o,
  output logic       new_message_o,
  output logic [7:0] message_o,
  output logic       msg_valid_o,
  output logic       msg_last_o,
  input  logic       ready_i,
  output logic [7:0] drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = LQ_AW + 1;

`ifdef FIX_LINK_DROP_PREFIX_EN
  localparam bit DROP_PREFIX = 1'b1;
`else
  localparam bit DROP_PREFIX = 1'b0;
`endif

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [PW-1:0]    wptr, wptr_nxt, rptr, rptr_nxt, frame_start;
  logic [LEN_W-1:0] frame_len, rem;
  logic [LEN_W-1:0] lq_mem [LEN_Q_DEPTH];
  logic [LQ_AW-1:0] lq_wr, lq_rd;
  logic [FW-1:0]    frame_cnt;
  logic [7:0]       drop_cnt, msg_q, ram_rdata;
  logic             full_q, lq_full;
  logic             store, begin_frame, commit, drop_frame;
  logic             accept, pop, load_byte;

  assign lq_full = (frame_cnt == FW'(LEN_Q_DEPTH));

  // ---------------- write side ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next      = w_state;
    store       = 1'b0;
    begin_frame = 1'b0;
    commit      = 1'b0;
    drop_frame  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (wr_en_i) begin
          begin_frame = 1'b1;
          if (DROP_PREFIX) w_next = W_FILL;
          else if (full_q) w_next = W_DROP;
          else begin
            store  = 1'b1;
            w_next = W_FILL;
          end
        end
      end
      W_FILL: begin
        if (wr_en_i) begin
          if (full_q) w_next = W_DROP;
          else        store  = 1'b1;
        end else if (end_i) begin
          w_next = W_IDLE;
          // A prefix-only frame has no payload and is silently forgotten.
          if (frame_len != '0) begin
            if (lq_full) drop_frame = 1'b1;
            else         commit     = 1'b1;
          end
        end
      end
      W_DROP: begin
        if (end_i) begin
          drop_frame = 1'b1;
          w_next     = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    wptr_nxt = wptr;
    if (drop_frame) wptr_nxt = frame_start;
    else if (store) wptr_nxt = wptr + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state     <= W_IDLE;
      wptr        <= '0;
      frame_start <= '0;
      frame_len   <= '0;
      lq_wr       <= '0;
      drop_cnt    <= '0;
      full_q      <= 1'b0;
    end else begin
      w_state <= w_next;
      wptr    <= wptr_nxt;
      // Uncommitted bytes count toward full, so the flag tracks raw pointers.
      full_q  <= ((wptr_nxt - rptr_nxt) == PW'(DEPTH));
      if (begin_frame) begin
        frame_start <= wptr;
        frame_len   <= {{(LEN_W-1){1'b0}}, store};
      end else if (store) begin
        frame_len <= frame_len + LEN_W'(1);
      end
      if (commit) lq_wr <= lq_wr + LQ_AW'(1);
      if (drop_frame && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) lq_mem[lq_wr] <= frame_len;
  end

  // ---------------- read side ----------------
  always_comb begin
    r_next = r_state;
    accept = 1'b0;
    pop    = 1'b0;
    unique case (r_state)
      R_IDLE:     if (frame_cnt != '0) r_next = R_ANNOUNCE;
      R_ANNOUNCE: r_next = R_STREAM;
      R_STREAM: begin
        if (ready_i) begin
          accept = 1'b1;
          if (rem == LEN_W'(1)) begin
            pop    = 1'b1;
            r_next = R_GAP;
          end
        end
      end
      // Chaining straight into the next announce keeps the inter-message
      // spacing at two cycles when another frame is already waiting.
      R_GAP:   r_next = (frame_cnt != '0) ? R_ANNOUNCE : R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign rptr_nxt  = accept ? rptr + PW'(1) : rptr;
  assign load_byte = (r_state == R_ANNOUNCE) || (accept && !pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      rptr      <= '0;
      rem       <= '0;
      lq_rd     <= '0;
      frame_cnt <= '0;
      msg_q     <= '0;
    end else begin
      r_state <= r_next;
      rptr    <= rptr_nxt;
      if (r_state == R_ANNOUNCE) rem <= lq_mem[lq_rd];
      else if (accept)           rem <= rem - LEN_W'(1);
      if (load_byte) msg_q <= ram_rdata;
      if (pop) lq_rd <= lq_rd + LQ_AW'(1);
      unique case ({commit, pop})
        2'b10:   frame_cnt <= frame_cnt + FW'(1);
        2'b01:   frame_cnt <= frame_cnt - FW'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  fix_link_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wptr[AW-1:0]),
    .wdata (data_i),
    .raddr (rptr_nxt[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign fifo_full_o   = full_q;
  assign new_message_o = (r_state == R_ANNOUNCE);
  assign msg_valid_o   = (r_state == R_STREAM);
  assign msg_last_o    = (r_state == R_STREAM) && (rem == LEN_W'(1));
  assign message_o     = msg_q;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_fix_msg_link.sv
// Directed bench for fix_msg_link: a 512-deep and a 16-deep instance share
// stimulus; a negedge monitor logs pulses and accepted bytes for checking.
module tb_fix_msg_link;

  logic       clk = 1'b0;
  logic       rst, wr_en_i, end_i, ready_i;
  logic [7:0] data_i;

  logic       d_full, d_new, d_valid, d_last;
  logic [7:0] d_msg, d_drop;
  logic       s_full, s_new, s_valid, s_last;
  logic [7:0] s_msg, s_drop;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int end_cyc  = 0;
  int s_pulses = 0;

  logic [7:0] tx[$];
  logic [7:0] ex[$];
  logic [7:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];
  int         pulse_cyc[$];
  logic [7:0] s_rx[$];
  logic       s_rx_last[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fix_msg_link #(.DEPTH(512)) u_dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .data_i(data_i), .end_i(end_i),
    .fifo_full_o(d_full), .new_message_o(d_new), .message_o(d_msg),
    .msg_valid_o(d_valid), .msg_last_o(d_last), .ready_i(ready_i),
    .drop_cnt_o(d_drop)
  );

  fix_msg_link #(.DEPTH(16)) u_small (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .data_i(data_i), .end_i(end_i),
    .fifo_full_o(s_full), .new_message_o(s_new), .message_o(s_msg),
    .msg_valid_o(s_valid), .msg_last_o(s_last), .ready_i(ready_i),
    .drop_cnt_o(s_drop)
  );

  // A byte seen valid with ready high at the negedge is taken on the next posedge.
  always @(negedge clk) begin
    if (d_new) pulse_cyc.push_back(cyc);
    if (d_valid && ready_i) begin
      rx_data.push_back(d_msg);
      rx_last.push_back(d_last);
      rx_cyc.push_back(cyc);
    end
    if (s_new) s_pulses++;
    if (s_valid && ready_i) begin
      s_rx.push_back(s_msg);
      s_rx_last.push_back(s_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_str(input string s);
    tx.delete();
    for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
    ex = tx;
  endtask

  task automatic send_range(input int lo, input int n, input bit do_end);
    for (int i = lo; i < lo + n; i++) begin
      @(posedge clk); #1;
      wr_en_i = 1'b1;
      data_i  = tx[i];
    end
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    if (do_end) begin
      end_i = 1'b1;
      @(posedge clk); #1;
      end_i   = 1'b0;
      end_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string tag, input int base, input int first_len);
    check($sformatf("%s count", tag), rx_data.size() - base, ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      if (base + i < rx_data.size()) begin
        check($sformatf("%s byte%0d", tag, i), rx_data[base+i], ex[i]);
        check($sformatf("%s last%0d", tag, i), rx_last[base+i],
              (i == first_len - 1) || (i == ex.size() - 1));
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " full"},  d_full,  0);
    check({tag, " new"},   d_new,   0);
    check({tag, " msg"},   d_msg,   0);
    check({tag, " valid"}, d_valid, 0);
    check({tag, " last"},  d_last,  0);
    check({tag, " drop"},  d_drop,  0);
    check({tag, " s_full"}, s_full, 0);
    check({tag, " s_drop"}, s_drop, 0);
    check({tag, " s_valid"}, s_valid, 0);
  endtask

  initial begin
    int rb, pb, sp, sb, first_end;

    rst = 1'b0; wr_en_i = 1'b0; end_i = 1'b0; data_i = 8'h00; ready_i = 1'b1;
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b1;
    idle(2);

    // 20-byte FIX frame: forwarded by the deep link, overflows the 16-deep one.
    load_str("8=FIX.4.2^9=5^35=A^1");
    rb = rx_data.size(); pb = pulse_cyc.size(); sp = s_pulses;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 15) check("small full after 15", s_full, 0);
      if (i == 16) check("small full after 16", s_full, 1);
      wr_en_i = 1'b1;
      data_i  = tx[i];
    end
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    end_i   = 1'b1;
    @(posedge clk); #1;
    end_i   = 1'b0;
    end_cyc = cyc;
    idle(30);
    check("fix20 pulses", pulse_cyc.size() - pb, 1);
    if (pulse_cyc.size() > pb) check("fix20 pulse latency", pulse_cyc[pb], end_cyc + 1);
    if (rx_cyc.size() > rb)    check("fix20 first byte latency", rx_cyc[rb], end_cyc + 2);
    check_rx("fix20", rb, 20);
    check("small drop_cnt", s_drop, 1);
    check("small no pulse", s_pulses - sp, 0);
    check("small full cleared", s_full, 0);
    check("big drop_cnt", d_drop, 0);

    // Frame after the drop is forwarded intact by both links.
    load_str("ABCDE");
    rb = rx_data.size(); sp = s_pulses; sb = s_rx.size();
    send_range(0, 5, 1'b1);
    idle(20);
    check_rx("post-drop", rb, 5);
    check("small post-drop pulses", s_pulses - sp, 1);
    check("small post-drop count", s_rx.size() - sb, 5);
    for (int i = 0; i < 5; i++) begin
      if (sb + i < s_rx.size()) begin
        check($sformatf("small byte%0d", i), s_rx[sb+i], ex[i]);
        check($sformatf("small last%0d", i), s_rx_last[sb+i], i == 4);
      end
    end

    // Two 10-byte frames back to back.
    load_str("0123456789abcdefghij");
    rb = rx_data.size(); pb = pulse_cyc.size();
    send_range(0, 10, 1'b1);
    first_end = end_cyc;
    send_range(10, 10, 1'b1);
    idle(40);
    check("b2b pulses", pulse_cyc.size() - pb, 2);
    if (pulse_cyc.size() > pb) check("b2b first latency", pulse_cyc[pb], first_end + 1);
    if (pulse_cyc.size() > pb + 1 && rx_cyc.size() > rb + 9)
      check("b2b spacing", pulse_cyc[pb+1] - rx_cyc[rb+9], 2);
    check_rx("b2b", rb, 10);

    // Toggling ready: each byte held while stalled, one accept every 2 cycles.
    load_str("HELLOWORLD12");
    rb = rx_data.size();
    ready_i = 1'b0;
    send_range(0, 12, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ready_i = ~ready_i;
    end
    ready_i = 1'b1;
    idle(10);
    check_rx("toggle", rb, 12);
    if (rx_cyc.size() > rb + 11) check("toggle span", rx_cyc[rb+11] - rx_cyc[rb], 22);

    // Prefix handling: leading framing byte stripped only when enabled.
    tx.delete();
    tx.push_back(8'h00);
    for (int i = 0; i < 5; i++) tx.push_back(8'h41 + 8'(i));
    ex = tx;
`ifdef FIX_LINK_DROP_PREFIX_EN
    void'(ex.pop_front());
`endif
    rb = rx_data.size(); pb = pulse_cyc.size();
    send_range(0, 6, 1'b1);
    idle(20);
    check("prefix pulses", pulse_cyc.size() - pb, 1);
    check_rx("prefix", rb, ex.size());

    tx.delete();
    tx.push_back(8'h01);
    pb = pulse_cyc.size();
    send_range(0, 1, 1'b1);
    idle(10);
`ifdef FIX_LINK_DROP_PREFIX_EN
    check("one-byte pulses", pulse_cyc.size() - pb, 0);
`else
    check("one-byte pulses", pulse_cyc.size() - pb, 1);
`endif

    // Reset while a message is stalled on the output and another is half written.
    load_str("Z1");
    ready_i = 1'b0;
    send_range(0, 2, 1'b1);
    idle(4);
    check("pre-rst valid", d_valid, 1);
    check("pre-rst msg", d_msg, 8'h5A);
    load_str("0123456789ABCDE");
    send_range(0, 7, 1'b0);
    rst = 1'b0;
    #1;
    check_zero_outputs("mid-rst");
    @(posedge clk); #1;
    rst = 1'b1;
    ready_i = 1'b1;
    idle(2);
    load_str("NEWFRAME");
    rb = rx_data.size(); pb = pulse_cyc.size();
    send_range(0, 8, 1'b1);
    idle(30);
    check("post-rst pulses", pulse_cyc.size() - pb, 1);
    check_rx("post-rst", rb, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
